// File: rtl/cla_pkg.sv
// Shared constants and helpers for the pipelined CLA adder.
package cla_pkg;

  localparam logic CLA_OP_ADD = 1'b0;
  localparam logic CLA_OP_SUB = 1'b1;

  // Returns 0 for an illegal split so the top can reject it at elaboration.
  function automatic int cla_ngroup(
    input int width,
    input int group
  );
    if (group < 1 || width < group) return 0;
    if ((width % group) != 0) return 0;
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             gg,
  output logic             gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP-1:0] c;
  logic             gk;
  logic             pk;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is a flat sum-of-products over g/p, not a ripple.
  always_comb begin
    c  = '0;
    gk = 1'b0;
    pk = 1'b1;
    gg = 1'b0;
    gp = 1'b1;
    for (int i = 0; i < GROUP; i++) begin
      gk = 1'b0;
      pk = 1'b1;
      for (int j = i - 1; j >= 0; j--) begin
        gk = gk | (pk & g[j]);
        pk = pk & p[j];
      end
      c[i] = gk | (pk & cin);
    end
    for (int j = GROUP - 1; j >= 0; j--) begin
      gg = gg | (gp & g[j]);
      gp = gp & p[j];
    end
  end

  assign sum  = p ^ c;
  assign cout = gg | (gp & cin);

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined WIDTH-bit CLA adder/subtractor, one GROUP slice per stage.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             In_Valid,
  output logic             In_Ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [WIDTH-1:0] Sum_out,
  output logic             Cout_out,
  output logic             Ovf_out,
  output logic             Zero_out
);

  localparam int NGROUP = cla_ngroup(WIDTH, GROUP);
  localparam int LAST   = NGROUP - 1;

  if (NGROUP < 1) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a multiple of GROUP");
  end

  logic en;
  logic rdy_q;

  logic [WIDTH-1:0] s_a [NGROUP];
  logic [WIDTH-1:0] s_b [NGROUP];
  logic             s_c [NGROUP];
  logic             s_v [NGROUP];
  logic [WIDTH-1:0] n_a [NGROUP];
  logic             n_c [NGROUP];
  logic [GROUP-1:0] g_sum [NGROUP];
  logic [NGROUP-1:0] la_gg;
  logic [NGROUP-1:0] la_gp;
  logic             unused_la;

  assign en       = !Out_Valid || Out_Ready;
  assign In_Ready = rdy_q && en;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) rdy_q <= 1'b0;
    else          rdy_q <= 1'b1;
  end

  assign s_v[0] = In_Valid && In_Ready;
  assign s_a[0] = A;
  assign s_b[0] = (Sub == CLA_OP_SUB) ? ~B : B;
  assign s_c[0] = (Sub == CLA_OP_ADD) ? Cin : ~Cin;

  // The A word rotates right one slice per stage; finished sum
  // slices enter at the top, so after NGROUP stages it is the sum.
  for (genvar k = 0; k < NGROUP; k++) begin : g_stage
    cla_group #(
      .GROUP (GROUP)
    ) u_grp (
      .a    (s_a[k][GROUP-1:0]),
      .b    (s_b[k][GROUP-1:0]),
      .cin  (s_c[k]),
      .sum  (g_sum[k]),
      .cout (n_c[k]),
      .gg   (la_gg[k]),
      .gp   (la_gp[k])
    );

    assign n_a[k] = (s_a[k] >> GROUP)
                  | (WIDTH'(g_sum[k]) << (WIDTH - GROUP));

    if (k < LAST) begin : g_reg
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;

      always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          v_q <= s_v[k];
          c_q <= n_c[k];
          a_q <= n_a[k];
          b_q <= s_b[k] >> GROUP;
        end
      end

      assign s_v[k+1] = v_q;
      assign s_c[k+1] = c_q;
      assign s_a[k+1] = a_q;
      assign s_b[k+1] = b_q;
    end
  end

  assign unused_la = ^{la_gg, la_gp};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Out_Valid <= 1'b0;
      Sum_out   <= '0;
      Cout_out  <= 1'b0;
      Ovf_out   <= 1'b0;
      Zero_out  <= 1'b0;
    end else if (en) begin
      Out_Valid <= s_v[LAST];
      Sum_out   <= n_a[LAST];
      Cout_out  <= n_c[LAST];
      Ovf_out   <= (s_a[LAST][GROUP-1] == s_b[LAST][GROUP-1])
                && (g_sum[LAST][GROUP-1] != s_a[LAST][GROUP-1]);
      Zero_out  <= (n_a[LAST] == '0);
    end
  end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed-vector bench for cla_pipe_adder (WIDTH=16, GROUP=4).
module tb_cla_pipe_adder;

  logic        Clk;
  logic        Reset_n;
  logic        In_Valid;
  logic        In_Ready;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic        Sub;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Sum_out;
  logic        Cout_out;
  logic        Ovf_out;
  logic        Zero_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected packing: {cout, ovf, zero, sum[15:0]}
  logic [15:0] va [8] = '{16'h0FFF, 16'h00FF, 16'h1234, 16'hFFFF,
                          16'h8000, 16'h1000, 16'h8000, 16'hF0F0};
  logic [15:0] vb [8] = '{16'h0001, 16'h0F01, 16'h4321, 16'hFFFF,
                          16'h8000, 16'h0001, 16'h0001, 16'h0F0F};
  logic        vc [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  logic        vs [8] = '{0, 0, 0, 0, 0, 1, 1, 0};
  logic [18:0] ve [8] = '{19'h01000, 19'h01000, 19'h05555, 19'h4FFFF,
                          19'h70000, 19'h40FFF, 19'h67FFF, 19'h50000};

  logic [15:0] pa [4] = '{16'h0001, 16'h00F0, 16'hFFFE, 16'h0000};
  logic [15:0] pb [4] = '{16'h0002, 16'h0010, 16'h0001, 16'h0000};
  logic        ps [4] = '{0, 0, 0, 1};
  logic [18:0] pe [4] = '{19'h00003, 19'h00100, 19'h0FFFF, 19'h50000};

  cla_pipe_adder #(
    .WIDTH (16),
    .GROUP (4)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .In_Valid  (In_Valid),
    .In_Ready  (In_Ready),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .Sub       (Sub),
    .Out_Valid (Out_Valid),
    .Out_Ready (Out_Ready),
    .Sum_out   (Sum_out),
    .Cout_out  (Cout_out),
    .Ovf_out   (Ovf_out),
    .Zero_out  (Zero_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [18:0] obs();
    return {Cout_out, Ovf_out, Zero_out, Sum_out};
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic drive(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        ci,
    input logic        sub
  );
    In_Valid = 1'b1;
    A        = a;
    B        = b;
    Cin      = ci;
    Sub      = sub;
  endtask

  task automatic run_one(
    input string       tag,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        ci,
    input logic        sub,
    input logic [18:0] want
  );
    int lat;
    @(negedge Clk);
    chk({tag, ".rdy"}, In_Ready, 1);
    drive(a, b, ci, sub);
    lat = 0;
    do begin
      @(negedge Clk);
      In_Valid = 1'b0;
      lat++;
    end while (!Out_Valid && lat < 10);
    chk({tag, ".lat"}, lat, 4);
    chk({tag, ".res"}, obs(), want);
  endtask

  initial begin
    int k;
    int stale;
    Reset_n   = 1'b1;
    In_Valid  = 1'b0;
    Out_Ready = 1'b1;
    A         = '0;
    B         = '0;
    Cin       = 1'b0;
    Sub       = 1'b0;
    #2 Reset_n = 1'b0;

    @(negedge Clk);
    chk("rst.ovalid", Out_Valid, 0);
    chk("rst.iready", In_Ready, 0);
    chk("rst.outs", obs(), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    #1 chk("rst.rel.iready", In_Ready, 0);
    @(negedge Clk);
    chk("rst.rise.iready", In_Ready, 1);

    run_one("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 19'h50000);
    run_one("sovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 19'h28000);
    run_one("sub0", 16'h0005, 16'h0007, 1'b0, 1'b1, 19'h0FFFE);
    run_one("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1, 19'h0FFFD);

    // Back-to-back stream, one op per cycle.
    @(negedge Clk);
    drive(va[0], vb[0], vc[0], vs[0]);
    k = 0;
    for (int e = 1; e <= 16; e++) begin
      @(negedge Clk);
      if (e < 8) drive(va[e], vb[e], vc[e], vs[e]);
      else       In_Valid = 1'b0;
      if (Out_Valid) begin
        if (k < 8) begin
          chk($sformatf("b2b%0d.cyc", k), e, k + 4);
          chk($sformatf("b2b%0d.res", k), obs(), ve[k]);
        end
        k++;
      end
    end
    chk("b2b.count", k, 8);

    // Backpressure with four ops in flight.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      drive(pa[i], pb[i], 1'b0, ps[i]);
      if (i == 3) Out_Ready = 1'b0;
    end
    @(negedge Clk);
    In_Valid = 1'b0;
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge Clk);
      chk($sformatf("bp.stall%0d.iready", s), In_Ready, 0);
      chk($sformatf("bp.stall%0d.ovalid", s), Out_Valid, 1);
      chk($sformatf("bp.stall%0d.res", s), obs(), pe[0]);
    end
    Out_Ready = 1'b1;
    k = 0;
    for (int e = 0; e < 10; e++) begin
      if (e > 0) @(negedge Clk);
      if (Out_Valid) begin
        if (k < 4) begin
          chk($sformatf("bp.drain%0d.cyc", k), e, k);
          chk($sformatf("bp.drain%0d.res", k), obs(), pe[k]);
        end
        k++;
      end
    end
    chk("bp.count", k, 4);

    // Reset with three ops in flight, one already at the output.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      drive(va[i], vb[i], vc[i], vs[i]);
    end
    @(negedge Clk);
    In_Valid = 1'b0;
    @(negedge Clk);
    chk("mid.pre.ovalid", Out_Valid, 1);
    Reset_n = 1'b0;
    #1 chk("mid.async.ovalid", Out_Valid, 0);
    chk("mid.async.outs", obs(), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    stale = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge Clk);
      if (Out_Valid) stale++;
    end
    chk("mid.stale", stale, 0);

    run_one("post", 16'h0ABC, 16'h1234, 1'b0, 1'b0, 19'h01CF0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor. Generalises the team's registered 4-bit CLA to WIDTH bits.
- The datapath is split into GROUP-bit CLA slices, with one slice per pipeline stage. Carry is registered between stages, and operand skew and result de-skew registers keep each op's slices aligned.
- Valid/ready handshake on input and output; adds subtract mode and Zero/Overflow flags.
- Sits between operand-fetch logic and the result writeback in the FPGA arithmetic datapath.

Parameters:
- WIDTH, 16, operand/result width. Must be an integer multiple of GROUP, with WIDTH >= GROUP.
- GROUP, 4, bits per CLA slice (one pipeline stage each).
- NGROUP (derived, not overridable), WIDTH/GROUP, pipeline depth in cycles.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- In_Valid  in  1  operand beat valid.
- In_Ready  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- Cin  in  1  carry-in (add) / borrow-in (sub).
- Sub  in  1  0 = A+B+Cin; 1 = A-B-Cin.
- Out_Valid  out  1  result beat valid.
- Out_Ready  in  1  downstream accepts the result.
- Sum_out  out  WIDTH  result.
- Cout_out  out  1  carry-out (add); NOT-borrow (sub).
- Ovf_out  out  1  signed two's-complement overflow.
- Zero_out  out  1  Sum_out == 0.

Behaviour:
- Reset:
  - Reset_n low asynchronously clears all stage valid bits, carry registers, skew registers and outputs.
  - During reset: Out_Valid=0, Sum_out=0, Cout_out=0, Ovf_out=0, Zero_out=0, In_Ready=0.
  - In_Ready rises the first Clk edge after Reset_n deasserts.
  - Reset mid-operation discards all in-flight ops; no partial result is ever presented.
- Arithmetic:
  - Stage-0 input: Beff = Sub ? ~B : B; c0 = Sub ? ~Cin : Cin.
  - Result = A + Beff + c0, taken modulo 2^WIDTH. Cout_out = carry out of bit WIDTH-1.
  - Ovf_out = (A[MSB] == Beff[MSB]) && (Sum[MSB] != A[MSB]).
  - Zero_out is computed over the final assembled Sum.
- Slice logic: each slice computes group G/P lookahead internally (no ripple inside the slice) and its group carry-out. The carry register between slices feeds the next stage.
- Pipeline and latency:
  - Slice k is evaluated in stage k.
  - A/Beff bits for slices above k travel in skew registers.
  - Computed low slices travel in de-skew registers so the full Sum is aligned at the output register.
  - Latency is exactly NGROUP cycles from the accepting edge (In_Valid && In_Ready) to Out_Valid=1.
  - Throughput is 1 op/cycle while Out_Ready=1.
- Handshake:
  - Global pipeline enable: en = !Out_Valid || Out_Ready. In_Ready = en.
  - An input beat is accepted only on In_Valid && In_Ready.
  - When en=0, every stage register holds, including bubbles (no bubble collapse).
  - Out_Valid, once high, stays high with Sum_out/flags stable until Out_Ready=1.
  - A/B/Cin/Sub are ignored when In_Valid=0; bubbles propagate as valid=0 with don't-care data.
- Simultaneous events: accept and emit in the same cycle is legal when Out_Ready=1.
- Degenerate case: WIDTH == GROUP gives NGROUP=1, i.e. a single registered stage with latency 1.

Decomposition:
- Shared package cla_pkg:
  - Localparams CLA_OP_ADD=1'b0 and CLA_OP_SUB=1'b1.
  - A function computing NGROUP with an elaboration-time check of WIDTH % GROUP == 0.
- Sub-module cla_group:
  - Purely combinational, GROUP-bit slice.
  - Inputs: a, b, cin. Outputs: sum, cout, gg, gp.
  - Instantiated NGROUP times in a generate loop; all registers live in cla_pipe_adder.

Test Plan (WIDTH=16, GROUP=4, latency 4):
- Wrap-around: add A=0xFFFF, B=0x0001, Cin=0 -> 4 cycles later Sum_out=0x0000, Cout_out=1, Zero_out=1, Ovf_out=0.
- Signed overflow: add A=0x7FFF, B=0x0001, Cin=0 -> Sum_out=0x8000, Ovf_out=1, Cout_out=0, Zero_out=0.
- Subtract with borrow:
  - Sub=1, A=0x0005, B=0x0007, Cin=0 -> Sum_out=0xFFFE, Cout_out=0, Ovf_out=0.
  - Same operands with Cin=1 -> Sum_out=0xFFFD.
- Back-to-back with cross-slice carry:
  - Stimulus: 8 consecutive ops with Out_Ready=1, including 0x0FFF+0x0001=0x1000 and 0x00FF+0x0F01=0x1000.
  - Required: results emerge in order on 8 consecutive cycles, first one 4 cycles after the first accept, each matching the reference model.
- Backpressure:
  - Stimulus: hold Out_Ready=0 with 4 ops in flight, for 5 cycles.
  - Required: In_Ready=0 and Sum_out/flags stable for those cycles. On Out_Ready=1, results drain in order, none lost or duplicated.
- Reset mid-flight: pulse Reset_n low for 1 cycle with 3 ops in flight -> Out_Valid falls immediately (asynchronously) and no stale result appears afterwards. A new op issued after reset returns in 4 cycles.
